merge_traffic_gen: RTL and testbench

Parametrised multi-channel packet traffic generator for merge-network benches and on-chip self-test. It drives NCH independent valid/ready source channels into the router local ports. Each channel emits NUM_PKT packets of PKT_LEN flits, with headers tagged by channel id and running flit index, and a configurable inter-packet gap. This replaces hand-instantiated per-node drivers and adds packetisation, flow-control compliance, completion reporting and optional randomised gaps.

---
 rtl/merge_tg_pkg.sv | 31 +++
 rtl/merge_tg_chan.sv | 133 +++++++++++++
 rtl/merge_traffic_gen.sv | 88 ++++++++
 tb/tb_merge_traffic_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/merge_tg_pkg.sv
// merge_tg_pkg: shared types and constants for the merge traffic generator.
//   flit_type_t  : two-bit flit type carried in the flit MSBs
//   chan_state_t : per-channel sequencer state
//   TYPE_W       : type field width; the channel id sits directly below it
//   LFSR_SEED    : per-channel LFSR seed base (channel index is XORed in)
//   LFSR_TAPS    : feedback mask for the right-shifting x^16+x^14+x^13+x^11+1 LFSR
// The LFSR constants only matter when MERGE_TG_LFSR_EN is defined.
package merge_tg_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_SEND,
    CH_GAP,
    CH_FIN
  } chan_state_t;

  // Flit layout: [DW-1 -: TYPE_W] type, [DW-1-TYPE_W -: SID_W] id, rest index.
  localparam int TYPE_W = 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift form: taps 16,14,13,11 map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/merge_tg_chan.sv
// merge_tg_chan: one source channel of the traffic generator.
// Emits NUM_PKT packets of PKT_LEN flits with a GAP-cycle pause after each
// non-final tail. valid_o is decoded from registered state only, so it never
// depends on ready_i, and data_o is held until the flit is accepted.
// Optional feature macro MERGE_TG_LFSR_EN: adds a 16-bit LFSR that lengthens
// each gap by lfsr[1:0] and inserts one-cycle bubbles before body/tail flits.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : qualified run start (only acted on in IDLE/FIN)
//   ready_i   : sink ready
//   valid_o   : flit valid
//   data_o    : flit {type, channel id, running index}
//   busy_o    : channel in SEND or GAP
//   fin_o     : channel in FIN
module merge_tg_chan
  import merge_tg_pkg::*;
#(
  parameter int DW      = 32,
  parameter int SID_W   = 4,
  parameter int PKT_LEN = 4,
  parameter int NUM_PKT = 16,
  parameter int GAP     = 2,
  parameter int CH_ID   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          busy_o,
  output logic          fin_o
);

  localparam int IDX_W = DW - TYPE_W - SID_W;
  localparam int K_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int P_W   = (NUM_PKT > 1) ? $clog2(NUM_PKT) : 1;
  localparam int G_W   = $clog2(GAP + 5);

  chan_state_t      r_state, w_state_nxt;
  logic [K_W-1:0]   r_k;
  logic [P_W-1:0]   r_p;
  logic [IDX_W-1:0] r_idx;
  logic [G_W-1:0]   r_gap;
  logic [G_W-1:0]   w_gap_len;
  logic             w_valid, w_accept, w_last_k, w_last_p, w_restart;
  flit_type_t       w_type;
`ifdef MERGE_TG_LFSR_EN
  logic [15:0]      r_lfsr;
  logic             r_bubble;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= CH_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_restart = start_i && (r_state == CH_IDLE || r_state == CH_FIN);
    w_valid   = (r_state == CH_SEND);
`ifdef MERGE_TG_LFSR_EN
    w_valid   = w_valid && !r_bubble;
`endif
    w_accept  = w_valid && ready_i;
    w_last_k  = (r_k == K_W'(PKT_LEN - 1));
    w_last_p  = (r_p == P_W'(NUM_PKT - 1));
`ifdef MERGE_TG_LFSR_EN
    w_gap_len = G_W'(GAP) + G_W'(r_lfsr[1:0]);
`else
    w_gap_len = G_W'(GAP);
`endif
    if (PKT_LEN == 1)     w_type = FT_SINGLE;
    else if (r_k == '0)   w_type = FT_HEAD;
    else if (w_last_k)    w_type = FT_TAIL;
    else                  w_type = FT_BODY;

    w_state_nxt = r_state;
    unique case (r_state)
      CH_IDLE: if (w_restart) w_state_nxt = CH_SEND;
      CH_SEND: begin
        if (w_accept && w_last_k) begin
          if (w_last_p)              w_state_nxt = CH_FIN;
          else if (w_gap_len != '0)  w_state_nxt = CH_GAP;
        end
      end
      CH_GAP:  if (r_gap == '0) w_state_nxt = CH_SEND;
      CH_FIN:  if (w_restart) w_state_nxt = CH_SEND;
    endcase
  end

  // r_gap is a down-counter loaded with gap_len-1 so GAP state lasts gap_len cycles.
  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_k   <= '0;
      r_p   <= '0;
      r_idx <= '0;
      r_gap <= '0;
`ifdef MERGE_TG_LFSR_EN
      r_lfsr   <= LFSR_SEED ^ 16'(CH_ID);
      r_bubble <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_idx <= r_idx + IDX_W'(1);
        if (w_last_k) begin
          r_k   <= '0;
          r_p   <= r_p + P_W'(1);
          r_gap <= w_gap_len - G_W'(1);
`ifdef MERGE_TG_LFSR_EN
          r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
`endif
        end else begin
          r_k <= r_k + K_W'(1);
`ifdef MERGE_TG_LFSR_EN
          r_bubble <= r_lfsr[2];
`endif
        end
      end else if (r_state == CH_GAP && r_gap != '0) begin
        r_gap <= r_gap - G_W'(1);
      end
`ifdef MERGE_TG_LFSR_EN
      // A bubble is only ever set on an accept, which needs !r_bubble.
      if (r_bubble) r_bubble <= 1'b0;
`endif
    end
  end

  assign valid_o = w_valid;
  assign data_o  = w_valid ? {w_type, SID_W'(CH_ID), r_idx} : '0;
  assign busy_o  = (r_state == CH_SEND) || (r_state == CH_GAP);
  assign fin_o   = (r_state == CH_FIN);

endmodule

// File: rtl/merge_traffic_gen.sv
// merge_traffic_gen: NCH independent valid/ready packet sources.
// Holds start qualification (start ignored while busy), busy/done reduction
// and the saturating count of accepted flits. Channel logic is in merge_tg_chan.
// Optional feature macro MERGE_TG_LFSR_EN (randomised gaps/bubbles) is
// implemented inside merge_tg_chan.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : one-cycle run start
//   ready_i     : per-channel sink ready
//   valid_o     : per-channel flit valid
//   data_o      : per-channel flit, channel c at [c*DW +: DW]
//   busy_o      : any channel in SEND or GAP
//   done_o      : sticky, all channels finished; cleared by next accepted start
//   flit_cnt_o  : flits accepted this run, saturating
module merge_traffic_gen
  import merge_tg_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int DW      = 32,
  parameter int SID_W   = 4,
  parameter int PKT_LEN = 4,
  parameter int NUM_PKT = 16,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [NCH-1:0]    valid_o,
  output logic [NCH*DW-1:0] data_o,
  input  logic [NCH-1:0]    ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       flit_cnt_o
);

  localparam int PC_W = $clog2(NCH + 1);

  logic [NCH-1:0]  w_busy_ch, w_fin_ch, w_acc;
  logic            w_start_acc, w_all_fin;
  logic [PC_W-1:0] w_pop;
  logic [32:0]     w_sum;
  logic            r_done;
  logic [31:0]     r_cnt;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    merge_tg_chan #(
      .DW      (DW),
      .SID_W   (SID_W),
      .PKT_LEN (PKT_LEN),
      .NUM_PKT (NUM_PKT),
      .GAP     (GAP),
      .CH_ID   (c)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .start_i (w_start_acc),
      .ready_i (ready_i[c]),
      .valid_o (valid_o[c]),
      .data_o  (data_o[c*DW +: DW]),
      .busy_o  (w_busy_ch[c]),
      .fin_o   (w_fin_ch[c])
    );
  end

  always_comb begin
    busy_o      = |w_busy_ch;
    w_all_fin   = &w_fin_ch;
    w_start_acc = start_i && !busy_o;
    w_acc       = valid_o & ready_i;
    w_pop       = '0;
    for (int i = 0; i < NCH; i++) w_pop = w_pop + PC_W'(w_acc[i]);
    w_sum       = {1'b0, r_cnt} + 33'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= r_done | w_all_fin;
      r_cnt  <= w_sum[32] ? '1 : w_sum[31:0];
    end
  end

  assign done_o     = r_done;
  assign flit_cnt_o = r_cnt;

endmodule

// File: tb/tb_merge_traffic_gen.sv
module tb_merge_traffic_gen;

  localparam int NCH = 8, DW = 32, SID_W = 4, PKT_LEN = 4, NUM_PKT = 2, GAP = 2;
  localparam int TOT   = PKT_LEN * NUM_PKT;
  localparam int IDX_W = DW - 2 - SID_W;
  typedef logic [NCH*DW-1:0] wide_t;

  logic              clk = 1'b0;
  logic              rst, start_i;
  logic [NCH-1:0]    ready_i, valid_o;
  logic [NCH*DW-1:0] data_o;
  logic              busy_o, done_o;
  logic [31:0]       flit_cnt_o;

  logic              start_b;
  logic [1:0]        ready_b, valid_b;
  logic [2*DW-1:0]   data_b;
  logic              busy_b, done_b;
  logic [31:0]       cnt_b;

  always #5 clk = ~clk;

  merge_traffic_gen #(.NCH(NCH), .DW(DW), .SID_W(SID_W), .PKT_LEN(PKT_LEN),
                      .NUM_PKT(NUM_PKT), .GAP(GAP)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o), .flit_cnt_o(flit_cnt_o));

  // Single-flit packets, no gap.
  merge_traffic_gen #(.NCH(2), .DW(DW), .SID_W(SID_W), .PKT_LEN(1),
                      .NUM_PKT(3), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .valid_o(valid_b), .data_o(data_b),
    .ready_i(ready_b), .busy_o(busy_b), .done_o(done_b), .flit_cnt_o(cnt_b));

  int checks = 0, failures = 0;

  // Reference model: flits accepted so far and remaining idle cycles per channel.
  int     m_n[NCH];
  int     m_gap[NCH];
  bit     m_started[NCH];
  bit     m_done;
  longint m_cnt;

  function automatic logic [DW-1:0] mk_flit(int c, int n, int plen);
    int k = n % plen;
    logic [1:0] t;
    if (plen == 1)          t = 2'b11;
    else if (k == 0)        t = 2'b01;
    else if (k == plen - 1) t = 2'b10;
    else                    t = 2'b00;
    return {t, SID_W'(c), IDX_W'(n)};
  endfunction

  function automatic bit m_valid(int c);
    return m_started[c] && m_n[c] < TOT && m_gap[c] == 0;
  endfunction

  function automatic bit m_busy();
    bit b = 1'b0;
    for (int c = 0; c < NCH; c++) if (m_started[c] && m_n[c] < TOT) b = 1'b1;
    return b;
  endfunction

  function automatic bit m_all_fin();
    bit f = 1'b1;
    for (int c = 0; c < NCH; c++) if (!(m_started[c] && m_n[c] == TOT)) f = 1'b0;
    return f;
  endfunction

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit fin_before  = m_all_fin();
    bit busy_before = m_busy();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin m_n[c] = 0; m_gap[c] = 0; m_started[c] = 1'b0; end
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (start_i && !busy_before) begin
      for (int c = 0; c < NCH; c++) begin m_n[c] = 0; m_gap[c] = 0; m_started[c] = 1'b1; end
      m_done = 1'b0;
      m_cnt  = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_valid(c) && ready_i[c]) begin
          m_n[c]++;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (m_n[c] % PKT_LEN == 0 && m_n[c] < TOT) m_gap[c] = GAP;
        end else if (m_gap[c] > 0) begin
          m_gap[c]--;
        end
      end
      m_done = m_done | fin_before;
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] ev;
    wide_t          ed;
    for (int c = 0; c < NCH; c++) begin
      ev[c] = m_valid(c);
      ed[c*DW +: DW] = ev[c] ? mk_flit(c, m_n[c], PKT_LEN) : '0;
    end
    chk("valid", wide_t'(valid_o), wide_t'(ev));
    chk("data", data_o, ed);
    chk("busy", wide_t'(busy_o), wide_t'(m_busy()));
    chk("done", wide_t'(done_o), wide_t'(m_done));
    chk("flit_cnt", wide_t'(flit_cnt_o), wide_t'(m_cnt[31:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_until_done(input int budget, input int pct, input bit poke);
    int cyc = 0;
    while (done_o !== 1'b1 && cyc < budget) begin
      for (int c = 0; c < NCH; c++) ready_i[c] = ($urandom_range(0, 99) < pct);
      start_i = poke && ($urandom_range(0, 19) == 0);
      tick();
      start_i = 1'b0;
      cyc++;
    end
    chk("run_done_within_budget", wide_t'(done_o), wide_t'(1'b1));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b1; ready_i = '1;
    start_b = 1'b0; ready_b = 2'b11;
    // Reset held with start asserted: reset must win.
    repeat (3) tick();
    chk("start_during_rst", wide_t'(busy_o), '0);
    rst = 1'b0; start_i = 1'b0;
    tick();

    // Directed run, all ready.
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("ch3_head0", wide_t'(data_o[3*DW +: DW]), wide_t'(32'h4C00_0000));
    repeat (3) tick();
    chk("ch3_tail0", wide_t'(data_o[3*DW +: DW]), wide_t'(32'h8C00_0003));
    tick();
    chk("ch3_gap", wide_t'(valid_o[3]), '0);
    repeat (2) tick();
    chk("ch3_head1", wide_t'(data_o[3*DW +: DW]), wide_t'(32'h4C00_0004));
    run_until_done(40, 100, 1'b0);
    chk("run1_flit_cnt", wide_t'(flit_cnt_o), wide_t'(32'd64));

    // Restart clears done/count; stall channel 5 mid-packet; start pulse while busy.
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("restart_done_clr", wide_t'(done_o), '0);
    repeat (2) tick();
    ready_i = 8'hDF;
    for (int i = 0; i < 20; i++) begin
      start_i = (i == 5);
      tick();
      start_i = 1'b0;
    end
    chk("ch5_stalled_valid", wide_t'(valid_o[5]), wide_t'(1'b1));
    ready_i = '1;
    run_until_done(60, 100, 1'b0);
    chk("run2_flit_cnt", wide_t'(flit_cnt_o), wide_t'(32'd64));

    // Random back-pressure with stray start pulses.
    for (int r = 0; r < 6; r++) begin
      start_i = 1'b1; tick(); start_i = 1'b0;
      run_until_done(600, 30 + 10 * r, 1'b1);
    end

    // Reset while channel 0 presents body flit 2, then a fresh start.
    ready_i = '1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1; tick();
    chk("rst_midrun_valid", wide_t'(valid_o), '0);
    rst = 1'b0; tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("restart_head_ch0", wide_t'(data_o[DW-1:0]), wide_t'(32'h4000_0000));
    run_until_done(40, 100, 1'b0);

    // Single-flit configuration: SINGLE flits back to back, indices 0..2.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_valid", wide_t'(valid_b), wide_t'(2'b11));
      chk("b_data", wide_t'(data_b), wide_t'({mk_flit(1, i, 1), mk_flit(0, i, 1)}));
      tick();
    end
    chk("b_valid_end", wide_t'(valid_b), '0);
    chk("b_done_not_yet", wide_t'(done_b), '0);
    tick();
    chk("b_done", wide_t'(done_b), wide_t'(1'b1));
    chk("b_flit_cnt", wide_t'(cnt_b), wide_t'(32'd6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
